// File: rtl/dmem_pkg.sv
// Shared definitions for the block-granular data memory and the data cache that drives it.
// Line width, block address width, FSM state encoding and the line index helper live here.
package dmem_pkg;

    localparam int BLOCK_W = 128;
    localparam int ADDR_W  = 28;
    localparam int CNT_W   = 4;

    typedef logic [BLOCK_W-1:0] line_t;
    typedef logic [ADDR_W-1:0]  blockAddr_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Upper address bits are dropped on purpose, so distinct blocks may alias onto one line.
    function automatic logic [7:0] blockIndex8(input blockAddr_t addr);
        return addr[7:0];
    endfunction

endpackage

// File: rtl/block_data_memory_if.sv
// Refill/writeback bus between the data cache (master) and the block data memory (slave).
interface block_data_memory_if;
    import dmem_pkg::*;

    logic       read;
    logic       write;
    blockAddr_t address;
    line_t      writedata;
    line_t      readdata;
    logic       busywait;

    modport master (
        output read,
        output write,
        output address,
        output writedata,
        input  readdata,
        input  busywait
    );

    modport slave (
        input  read,
        input  write,
        input  address,
        input  writedata,
        output readdata,
        output busywait
    );

endinterface

// File: rtl/block_ram_array.sv
// Line storage with one synchronous write port and one synchronous read port.
// Only the read result register is reset; the array itself holds whatever was last written.
module block_ram_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  i_we,
    input  logic                  i_re,
    input  logic [DEPTH_LOG2-1:0] i_index,
    input  line_t                 i_wdata,
    output line_t                 o_rdata
);

    line_t r_mem [2**DEPTH_LOG2];
    line_t r_rdata;

    always_ff @(posedge clock) begin
        if (i_we) begin
            r_mem[i_index] <= i_wdata;
        end
    end

    // The read register holds its line until the next read, which is what the requester relies on.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_index];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/block_data_memory.sv
// Responder side of the data-cache refill/writeback bus: whole-line reads and writes
// completed after a fixed number of busy cycles, with a one-cycle DONE handshake.
module block_data_memory
    import dmem_pkg::*;
#(
    parameter int DEPTH_LOG2 = 8,
    parameter int LATENCY    = 5
) (
    input  logic                 clock,
    input  logic                 reset,
    block_data_memory_if.slave   bus
);

    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(LATENCY - 1);

    state_t                r_state;
    logic [CNT_W-1:0]      r_count;
    logic [DEPTH_LOG2-1:0] r_index;
    line_t                 r_wdata;
    logic                  r_isWrite;

    logic                  w_request;
    logic                  w_access;
    logic                  w_we;
    logic                  w_re;
    logic                  w_busy;
    line_t                 w_ramRdata;

    assign w_request = bus.read | bus.write;

    // Request, op and data are captured on acceptance so the requester may change them afterwards.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_count   <= '0;
            r_index   <= '0;
            r_wdata   <= '0;
            r_isWrite <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_request) begin
                        r_index   <= bus.address[DEPTH_LOG2-1:0];
                        r_wdata   <= bus.writedata;
                        r_isWrite <= bus.write;
                        r_count   <= LAT_LOAD;
                        r_state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (r_count == '0) begin
                        r_state <= DONE;
                    end else begin
                        r_count <= r_count - 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // IDLE reflects the request combinationally so the cache sees busy in the cycle it asks.
    always_comb begin
        w_busy = 1'b0;
        unique case (r_state)
            IDLE:    w_busy = w_request;
            BUSY:    w_busy = 1'b1;
            DONE:    w_busy = 1'b0;
            default: w_busy = 1'b0;
        endcase
    end

    assign w_access = (r_state == BUSY) && (r_count == '0);
    assign w_we     = w_access & r_isWrite;
    assign w_re     = w_access & ~r_isWrite;

    block_ram_array #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clock   (clock),
        .reset   (reset),
        .i_we    (w_we),
        .i_re    (w_re),
        .i_index (r_index),
        .i_wdata (r_wdata),
        .o_rdata (w_ramRdata)
    );

    assign bus.readdata = w_ramRdata;
    assign bus.busywait = w_busy;

    generate
        if (DEPTH_LOG2 < ADDR_W) begin : g_aliasBits
            logic w_unusedAddrBits;
            assign w_unusedAddrBits = ^bus.address[ADDR_W-1:DEPTH_LOG2];
        end
    endgenerate

endmodule

// File: doc/block_data_memory.md
Name: block_data_memory

Overview:
- Responder end of the data-cache refill/writeback interface: a block-granular (128-bit) backing data memory with fixed multi-cycle access latency.
- Serves whole-line reads (refill) and whole-line writes (dirty eviction) issued by the data cache controller.
- Signals completion by dropping busywait.
- Sits directly below the data cache; only the cache drives it.

Parameters:
- BLOCK_W, 128, line width in bits (4 x 32-bit words, word 0 in bits [31:0]).
- ADDR_W, 28, block address width (byte address bits [31:4]).
- DEPTH_LOG2, 8, log2 of stored lines; index = address[DEPTH_LOG2-1:0], upper bits ignored (aliasing permitted).
- LATENCY, 5, busy cycles per access after acceptance; legal range 1..15.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high.
- read  input  1  line read request; held high by requester until busywait low.
- write  input  1  line write request; held high by requester until busywait low.
- address  input  ADDR_W  block address; stable while request held.
- writedata  input  BLOCK_W  line to store; stable while write held.
- readdata  output  BLOCK_W  registered line read result; holds value until next completed read.
- busywait  output  1  high while an access is pending or in progress.

Behaviour:
- Interface: reset reset, asynchronous, active-high; clock clock.
- Reset: state IDLE, latency counter 0, readdata 0, internal latches cleared; busywait follows IDLE rule (0 while read=write=0). Array contents not reset (undefined until written).
- States: IDLE, BUSY, DONE.
- IDLE:
  - busywait = read | write, combinational, so the requester sees busy in the same cycle it raises a request.
  - On posedge with read|write: latch address, writedata and op; counter <= LATENCY-1; go BUSY.
- BUSY:
  - busywait = 1.
  - Counter decrements each edge.
  - On the edge where counter == 0: perform access and go DONE.
    - Write: array[index] <= latched writedata.
    - Read: readdata <= array[index].
- DONE:
  - busywait = 0 for exactly one cycle, regardless of read/write (prevents retrigger while the requester observes completion).
  - readdata is valid here and stays stable afterwards.
  - Next edge goes IDLE unconditionally.
  - A request still held in the following IDLE cycle is a new access.
- Latency: request raised in cycle 0 → busywait low in cycle LATENCY+1 (LATENCY=5 → 6 cycles high, low in cycle 6).
- read & write both high at acceptance: write wins, readdata unchanged.
- Inputs changing during BUSY are ignored (latched copy used).
- Reset during BUSY: access aborted, pending write not committed, array untouched, readdata 0.
- Back-to-back accesses (writeback then refill): minimum gap is the single DONE cycle plus the IDLE acceptance edge.
- Read-after-write to same index returns the new line.
- No partial-line writes.

Decomposition:
- Shared package dmem_pkg:
  - BLOCK_W, ADDR_W constants.
  - State enum (IDLE/BUSY/DONE).
  - Line type (BLOCK_W vector).
  - Shared with the data cache for mem_address/mem_writedata widths.
- Sub-module block_ram_array: 2^DEPTH_LOG2 x BLOCK_W storage, one synchronous write port, one synchronous read port (we, index, wdata, re, rdata).
- The FSM, counter and latches stay in block_data_memory.

Test Plan:
- Reset then idle → busywait 0, readdata 0; assert reset mid-BUSY of a write to index 3 → later read of index 3 does not return the aborted data.
- Write line 0x0123..CDEF to address 0x0000010 → busywait high cycles 0..5, low cycle 6 only; read same address → readdata = written line in its DONE cycle, held after request drops.
- Write A to 0x0000002, write B to 0x0000102 (alias at DEPTH_LOG2=8) → read 0x0000002 returns B.
- read & write both high with address 0x05, writedata all-ones → line stored, readdata keeps prior value.
- Writeback to 0x0000007 followed immediately by a refill read of 0x0000017 (eviction sequence) → two separate 6-cycle busy windows separated by one DONE cycle; correct data on the refill.
- Change address/writedata mid-BUSY → access uses values latched at acceptance.
